rx_acq_sequencer: RTL

//  Sequences one RX chain (reset, CIC decimation-rate load, settling, acquisition) per host command.

---
 rtl/rx_acq_sequencer_if.sv | 40 ++++
 rtl/rx_acq_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/rx_acq_sequencer_if.sv
// Command, RX-chain and RX-FIFO signals of one acquisition sequencer.
// The sequencer takes the master modport; the host/chain/FIFO side takes slave.
interface rx_acq_sequencer_if #(
  parameter int NSAMP_W = 16
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [15:0]        cmd_rate_i;
  logic [NSAMP_W-1:0] cmd_nsamp_i;
  logic               abort_i;
  logic               rx_rst_n_o;
  logic [15:0]        rate_axis_tdata_o;
  logic               rate_axis_tvalid_o;
  logic               rx_axis_tvalid_i;
  logic [63:0]        rx_axis_tdata_i;
  logic               rx_axis_tready_o;
  logic               out_tvalid_o;
  logic [63:0]        out_tdata_o;
  logic               out_tready_i;
  logic               busy_o;
  logic               done_o;
  logic [NSAMP_W-1:0] sample_cnt_o;
  logic [15:0]        drop_cnt_o;

  modport master (
    input  cmd_valid_i, cmd_rate_i, cmd_nsamp_i, abort_i,
    input  rx_axis_tvalid_i, rx_axis_tdata_i, out_tready_i,
    output cmd_ready_o, rx_rst_n_o, rate_axis_tdata_o, rate_axis_tvalid_o,
    output rx_axis_tready_o, out_tvalid_o, out_tdata_o,
    output busy_o, done_o, sample_cnt_o, drop_cnt_o
  );

  modport slave (
    output cmd_valid_i, cmd_rate_i, cmd_nsamp_i, abort_i,
    output rx_axis_tvalid_i, rx_axis_tdata_i, out_tready_i,
    input  cmd_ready_o, rx_rst_n_o, rate_axis_tdata_o, rate_axis_tvalid_o,
    input  rx_axis_tready_o, out_tvalid_o, out_tdata_o,
    input  busy_o, done_o, sample_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/rx_acq_sequencer.sv
// Per-command RX chain sequencer: chain reset, one-cycle rate load, settling discard,
// then zero-latency gated pass-through of exactly nsamp samples to the RX FIFO.
module rx_acq_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int SETTLE_SAMPS = 8,
  parameter int NSAMP_W      = 16,
  parameter int MIN_RATE     = 4
) (
  input logic                clk,
  input logic                rst,
  rx_acq_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RST, CFG, SETTLE, ACQ, DONE} state_t;

  localparam int                RST_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]  RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [15:0]       SETTLE_LAST = 16'((SETTLE_SAMPS > 0) ? SETTLE_SAMPS - 1 : 0);
  localparam logic [15:0]       MIN_RATE_V  = 16'(MIN_RATE);

  state_t             state, state_nx;
  logic [RST_W-1:0]   rst_cnt;
  logic [15:0]        settle_cnt;
  logic [15:0]        rate_q;
  logic [15:0]        rate_out;
  logic [NSAMP_W-1:0] nsamp_q;
  logic [NSAMP_W-1:0] sample_cnt;
  logic [NSAMP_W-1:0] sample_inc;
  logic [15:0]        drop_cnt;
  logic               accept;
  logic               xfer;
  logic               lost;
  logic               settle_done;

  assign sample_inc = sample_cnt + NSAMP_W'(1);

  always_comb begin
    accept      = (state == IDLE) && bus.cmd_valid_i;
    xfer        = (state == ACQ) && bus.rx_axis_tvalid_i && bus.out_tready_i;
    lost        = (state == ACQ) && bus.rx_axis_tvalid_i && !bus.out_tready_i;
    settle_done = (SETTLE_SAMPS == 0) ? 1'b1
                : (bus.rx_axis_tvalid_i && (settle_cnt == SETTLE_LAST));
    state_nx    = state;
    case (state)
      IDLE:    if (accept) state_nx = RST;
      RST:     if (rst_cnt == RST_LAST) state_nx = CFG;
      CFG:     state_nx = SETTLE;
      SETTLE:  if (settle_done) state_nx = (nsamp_q == '0) ? DONE : ACQ;
      ACQ:     if (xfer && (sample_inc == nsamp_q)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort outranks every other transition but never blocks an IDLE accept.
    if (bus.abort_i && (state != IDLE)) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      settle_cnt <= '0;
      rate_q     <= '0;
      rate_out   <= '0;
      nsamp_q    <= '0;
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rate_q     <= (bus.cmd_rate_i < MIN_RATE_V) ? MIN_RATE_V : bus.cmd_rate_i;
        nsamp_q    <= bus.cmd_nsamp_i;
        sample_cnt <= '0;
        drop_cnt   <= '0;
        rst_cnt    <= '0;
        settle_cnt <= '0;
      end
      if (state == RST) rst_cnt <= rst_cnt + RST_W'(1);
      // Rate output only changes as CFG is entered, so it is stable for the strobe.
      if ((state == RST) && (state_nx == CFG)) rate_out <= rate_q;
      if ((state == SETTLE) && bus.rx_axis_tvalid_i) settle_cnt <= settle_cnt + 16'd1;
      if (xfer) sample_cnt <= sample_inc;
      if (lost && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.cmd_ready_o        = (state == IDLE);
  assign bus.busy_o             = (state != IDLE);
  assign bus.done_o             = (state == DONE);
  assign bus.rate_axis_tvalid_o = (state == CFG);
  assign bus.rate_axis_tdata_o  = rate_out;
  assign bus.rx_rst_n_o         = (state == SETTLE) || (state == ACQ) || (state == DONE);
  assign bus.rx_axis_tready_o   = ((state == SETTLE) && (SETTLE_SAMPS != 0))
                                || ((state == ACQ) && bus.out_tready_i);
  assign bus.out_tvalid_o       = (state == ACQ) && bus.rx_axis_tvalid_i;
  assign bus.out_tdata_o        = bus.rx_axis_tdata_i;
  assign bus.sample_cnt_o       = sample_cnt;
  assign bus.drop_cnt_o         = drop_cnt;

endmodule
